// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU fetch front end.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4
    } fetch_state_t;

    // Size of one instruction in bytes; PC step between sequential fetches
    localparam int INSTR_BYTES = 4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response bundle between the
//                fetch stage (master) and the instruction memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_decode_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_reg
//  Description : IF/ID pipeline register. Per-cycle priority is
//                flush > stall > load > bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_decode_reg #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_flush,
    input  wire logic             i_stall,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_instr,
    input  wire logic [WIDTH-1:0] i_pc8,
    output logic      [WIDTH-1:0] o_instr,
    output logic      [WIDTH-1:0] o_pc8,
    output logic                  o_valid
);

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc8;
    logic             r_valid;

    // IF/ID contents: flush clears instruction/valid but keeps the PC field
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
            r_pc8   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_instr <= r_instr;
            r_pc8   <= r_pc8;
            r_valid <= r_valid;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc8   <= i_pc8;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc8   = r_pc8;
    assign o_valid = r_valid;

endmodule : fetch_decode_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns PCF, issues one request at a
//                time to a variable-latency instruction memory, handles
//                redirects, parks a response in a skid register while Decode
//                is stalled, and feeds the IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             StallF,
    input  wire logic             StallD,
    input  wire logic             FlushD,
    input  wire logic             BranchTakenE,
    input  wire logic [WIDTH-1:0] ALUResultE,
    input  wire logic             PCSrcW,
    input  wire logic [WIDTH-1:0] ResultW,
    fetch_stage_if.master         imem,
    output logic      [WIDTH-1:0] InstructionD,
    output logic      [WIDTH-1:0] PCPlus8D,
    output logic                  ValidD,
    output logic                  FetchBusyF
);

    fetch_state_t     r_state;
    fetch_state_t     w_next_state;
    logic [WIDTH-1:0] r_pcf;
    logic [WIDTH-1:0] w_pcf_next;
    logic [WIDTH-1:0] r_skid_instr;
    logic [WIDTH-1:0] r_skid_pc8;

    logic             w_redir;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_pc8;
    logic             w_req;
    logic             w_pc_adv;
    logic             w_skid_capture;
    logic             w_load;
    logic [WIDTH-1:0] w_load_instr;
    logic [WIDTH-1:0] w_load_pc8;

    // Execute redirect outranks Writeback redirect
    assign w_redir  = BranchTakenE | PCSrcW;
    assign w_target = BranchTakenE ? ALUResultE : ResultW;
    assign w_pc4    = r_pcf + WIDTH'(INSTR_BYTES);
    assign w_pc8    = r_pcf + WIDTH'(2 * INSTR_BYTES);

    // Next-state and control decode; a redirect racing a response discards it
    always_comb begin
        w_next_state   = r_state;
        w_req          = 1'b0;
        w_pc_adv       = 1'b0;
        w_skid_capture = 1'b0;
        w_load         = 1'b0;
        w_load_instr   = imem.imem_rdata;
        w_load_pc8     = w_pc8;
        case (r_state)
            IDLE: begin
                w_next_state = ISSUE;
            end
            ISSUE: begin
                if (!StallF && !w_redir) begin
                    w_req        = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (w_redir) begin
                    w_next_state = imem.imem_rvalid ? ISSUE : DROP;
                end else if (imem.imem_rvalid) begin
                    w_pc_adv = 1'b1;
                    if (StallD) begin
                        w_skid_capture = 1'b1;
                        w_next_state   = HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (w_redir) begin
                    w_next_state = ISSUE;
                end else if (!StallD) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid_instr;
                    w_load_pc8   = r_skid_pc8;
                    w_next_state = ISSUE;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    w_next_state = ISSUE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // PC update: redirect target beats sequential advance
    always_comb begin
        w_pcf_next = r_pcf;
        if (w_redir) begin
            w_pcf_next = w_target;
        end else if (w_pc_adv) begin
            w_pcf_next = w_pc4;
        end
    end

    // State and PC registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pcf   <= w_pcf_next;
        end
    end

    // Skid holds a response that arrived while Decode was stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_instr <= '0;
            r_skid_pc8   <= '0;
        end else if (w_skid_capture) begin
            r_skid_instr <= imem.imem_rdata;
            r_skid_pc8   <= w_pc8;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pcf;
    assign FetchBusyF     = (r_state == WAIT) || (r_state == DROP);

    fetch_decode_reg #(
        .WIDTH (WIDTH)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .i_flush (FlushD),
        .i_stall (StallD),
        .i_load  (w_load),
        .i_instr (w_load_instr),
        .i_pc8   (w_load_pc8),
        .o_instr (InstructionD),
        .o_pc8   (PCPlus8D),
        .o_valid (ValidD)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage with a
//                behavioural variable-latency instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
    logic [31:0] ALUResultE = '0, ResultW = '0;
    logic [31:0] InstructionD, PCPlus8D;
    logic        ValidD, FetchBusyF;

    int errors = 0;
    int checks = 0;
    int lat    = 1;

    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    int          mem_cnt;

    fetch_stage_if #(.WIDTH(32)) imem_bus ();

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .imem         (imem_bus.master),
        .InstructionD (InstructionD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .FetchBusyF   (FetchBusyF)
    );

    always #5 clk = ~clk;

    // Instruction contents: address 0 holds a fixed opcode, others are address-tagged
    function automatic logic [31:0] memdata(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE081_0002 : (32'hA000_0000 ^ a);
    endfunction

    // Memory model: answers each request 'lat' cycles after the request cycle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_addr   <= '0;
            mem_cnt    <= 0;
        end else if (imem_bus.imem_req) begin
            mem_addr   <= imem_bus.imem_addr;
            mem_cnt    <= lat - 1;
            mem_rvalid <= (lat == 1);
            mem_rdata  <= memdata(imem_bus.imem_addr);
        end else if (mem_cnt > 0) begin
            mem_cnt    <= mem_cnt - 1;
            mem_rvalid <= (mem_cnt == 1);
            mem_rdata  <= memdata(mem_addr);
        end else begin
            mem_rvalid <= 1'b0;
        end
    end

    assign imem_bus.imem_rvalid = mem_rvalid;
    assign imem_bus.imem_rdata  = mem_rdata;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        lat   = 3;
        reset = 1'b1;
        cyc();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: req=%b addr=%h want req=1 addr=00000000", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        checks++; if (FetchBusyF !== 1'b1) begin errors++; $display("FAIL reset_busy_wait: got %b want 1", FetchBusyF); end
        reset = 1'b0;
        #1;
        checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0 || PCPlus8D !== 32'h0) begin errors++; $display("FAIL reset_ifid: v=%b i=%h p=%h want 0", ValidD, InstructionD, PCPlus8D); end
        checks++; if (imem_bus.imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin errors++; $display("FAIL reset_ctrl: req=%b busy=%b want 0 0", imem_bus.imem_req, FetchBusyF); end
        cyc();
        lat   = 1;
        reset = 1'b1;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_noreq: got %b want 0", imem_bus.imem_req); end
        cyc();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_release_req: req=%b addr=%h want 1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_basic();
        cyc();
        checks++; if (FetchBusyF !== 1'b1 || ValidD !== 1'b0) begin errors++; $display("FAIL basic_wait: busy=%b v=%b want 1 0", FetchBusyF, ValidD); end
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hE081_0002 || PCPlus8D !== 32'h8) begin errors++; $display("FAIL basic_load0: v=%b i=%h p=%h want 1 e0810002 00000008", ValidD, InstructionD, PCPlus8D); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_req: req=%b addr=%h want 1 00000004", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL basic_bubble: v=%b want 0", ValidD); end
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0004 || PCPlus8D !== 32'hC) begin errors++; $display("FAIL basic_load4: v=%b i=%h p=%h want 1 a0000004 0000000c", ValidD, InstructionD, PCPlus8D); end
        checks++; if (imem_bus.imem_addr !== 32'h8) begin errors++; $display("FAIL basic_addr8: got %h want 00000008", imem_bus.imem_addr); end
    endtask

    task automatic test_stall_skid();
        StallD = 1'b1;
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0004) begin errors++; $display("FAIL skid_hold_wait: v=%b i=%h want 1 a0000004", ValidD, InstructionD); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++; if (imem_bus.imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin errors++; $display("FAIL skid_hold_noreq%0d: req=%b busy=%b want 0 0", k, imem_bus.imem_req, FetchBusyF); end
            checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0004 || PCPlus8D !== 32'hC) begin errors++; $display("FAIL skid_ifid_held%0d: v=%b i=%h p=%h want 1 a0000004 0000000c", k, ValidD, InstructionD, PCPlus8D); end
        end
        cyc();
        StallD = 1'b0;
        lat    = 2;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL skid_release_noreq: got %b want 0", imem_bus.imem_req); end
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0008 || PCPlus8D !== 32'h10) begin errors++; $display("FAIL skid_load: v=%b i=%h p=%h want 1 a0000008 00000010", ValidD, InstructionD, PCPlus8D); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hC) begin errors++; $display("FAIL skid_next_req: req=%b addr=%h want 1 0000000c", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL skid_once: v=%b want 0", ValidD); end
    endtask

    task automatic test_branch_drop();
        BranchTakenE = 1'b1;
        ALUResultE   = 32'h100;
        #1;
        checks++; if (FetchBusyF !== 1'b1 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait: busy=%b req=%b want 1 0", FetchBusyF, imem_bus.imem_req); end
        cyc();
        BranchTakenE = 1'b0;
        ALUResultE   = 32'h0;
        #1;
        checks++; if (FetchBusyF !== 1'b1 || ValidD !== 1'b0 || imem_bus.imem_rvalid !== 1'b1) begin errors++; $display("FAIL drop_state: busy=%b v=%b rv=%b want 1 0 1", FetchBusyF, ValidD, imem_bus.imem_rvalid); end
        cyc();
        lat = 1;
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL drop_discard: v=%b want 0", ValidD); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL drop_target_req: req=%b addr=%h want 1 00000100", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0100 || PCPlus8D !== 32'h108) begin errors++; $display("FAIL drop_after_load: v=%b i=%h p=%h want 1 a0000100 00000108", ValidD, InstructionD, PCPlus8D); end
    endtask

    task automatic test_redirect_priority();
        BranchTakenE = 1'b1; ALUResultE = 32'h40;
        PCSrcW       = 1'b1; ResultW    = 32'h80;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL prio_noreq: got %b want 0", imem_bus.imem_req); end
        cyc();
        BranchTakenE = 1'b0; PCSrcW = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin errors++; $display("FAIL prio_target: req=%b addr=%h want 1 00000040", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hA000_0040 || PCPlus8D !== 32'h48) begin errors++; $display("FAIL prio_load: v=%b i=%h p=%h want 1 a0000040 00000048", ValidD, InstructionD, PCPlus8D); end
        FlushD = 1'b1; StallD = 1'b1; StallF = 1'b1;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stallf_noreq: got %b want 0", imem_bus.imem_req); end
        cyc();
        checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0 || PCPlus8D !== 32'h48) begin errors++; $display("FAIL flush_stall: v=%b i=%h p=%h want 0 00000000 00000048", ValidD, InstructionD, PCPlus8D); end
        FlushD = 1'b0; StallD = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h44) begin errors++; $display("FAIL stallf_hold: req=%b addr=%h want 0 00000044", imem_bus.imem_req, imem_bus.imem_addr); end
        StallF = 1'b0;
    endtask

    task automatic test_wrap();
        PCSrcW  = 1'b1;
        ResultW = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_noreq: got %b want 0", imem_bus.imem_req); end
        cyc();
        PCSrcW  = 1'b0;
        ResultW = 32'h0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_bus.imem_req, imem_bus.imem_addr); end
        cyc();
        cyc();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'h5FFF_FFFC || PCPlus8D !== 32'h4) begin errors++; $display("FAIL wrap_load: v=%b i=%h p=%h want 1 5ffffffc 00000004", ValidD, InstructionD, PCPlus8D); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_skid();
        test_branch_drop();
        test_redirect_priority();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
